// File: rtl/button_cond.sv
// button_cond: push-button and slider-switch conditioner for the multiplier
// front panel.
//
// Each active-low button is inverted and synchronized through two flops. It is
// then debounced with a saturating stability counter that toggles the pressed
// level after DEBOUNCE_CYCLES consecutive disagreeing samples. A registered
// one-cycle pulse marks each accepted press; a release produces no pulse. The
// slider switches are two-flop synchronized only, and a snapshot of them is
// taken on every accepted ClrLd press.
//
// Ports
//   Clk            in   system clock
//   Reset          in   asynchronous, active-high reset
//   Run_n          in   raw Run button, active-low, asynchronous
//   ClearA_LoadB_n in   raw ClearA_LoadB button, active-low, asynchronous
//   S[7:0]         in   raw slider switches, asynchronous
//   Busy           in   downstream multiplier mid-operation
//   Run_lvl        out  debounced Run pressed level
//   ClrLd_lvl      out  debounced ClearA_LoadB pressed level
//   Run_pulse      out  one-cycle Run press event
//   ClrLd_pulse    out  one-cycle ClearA_LoadB press event
//   Sw[7:0]        out  synchronized switches
//   Sw_snap[7:0]   out  Sw captured on each accepted ClrLd_pulse
//
// Build option
//   BTN_COND_LOCKOUT_EN: presses whose pulse edge sees Busy=1 are dropped.
//   The pulse is suppressed and Sw_snap is left unchanged, but the levels
//   still track the buttons. Without the macro, Busy is ignored.

module button_cond #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_n,
  input  logic       ClearA_LoadB_n,
  input  logic [7:0] S,
  input  logic       Busy,
  output logic       Run_lvl,
  output logic       ClrLd_lvl,
  output logic       Run_pulse,
  output logic       ClrLd_pulse,
  output logic [7:0] Sw,
  output logic [7:0] Sw_snap
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1. The toggle happens on the
  // edge that would make it DEBOUNCE_CYCLES.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          run_meta, run_sync;
  logic          clr_meta, clr_sync;
  logic [CW-1:0] run_cnt, clr_cnt;
  logic [7:0]    s_meta;
  logic          run_rise, clr_rise;
  logic          lock;
  logic          run_fire, clr_fire;

  // Debounced level is about to go 0->1 on this edge.
  assign run_rise = run_sync & ~Run_lvl & (run_cnt >= CNT_LAST);
  assign clr_rise = clr_sync & ~ClrLd_lvl & (clr_cnt >= CNT_LAST);

`ifdef BTN_COND_LOCKOUT_EN
  assign lock = Busy;
`else
  assign lock = Busy & 1'b0;
`endif

  // Run wins a same-edge collision; the losing ClrLd press is dropped.
  assign run_fire = run_rise & ~lock;
  assign clr_fire = clr_rise & ~lock & ~run_fire;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_meta    <= 1'b0;
      run_sync    <= 1'b0;
      clr_meta    <= 1'b0;
      clr_sync    <= 1'b0;
      run_cnt     <= '0;
      clr_cnt     <= '0;
      Run_lvl     <= 1'b0;
      ClrLd_lvl   <= 1'b0;
      Run_pulse   <= 1'b0;
      ClrLd_pulse <= 1'b0;
      s_meta      <= 8'h00;
      Sw          <= 8'h00;
      Sw_snap     <= 8'h00;
    end else begin
      // Inversion sits at the first flop so reset (0) means released.
      run_meta <= ~Run_n;
      run_sync <= run_meta;
      clr_meta <= ~ClearA_LoadB_n;
      clr_sync <= clr_meta;

      if (run_sync == Run_lvl) begin
        run_cnt <= '0;
      end else if (run_cnt >= CNT_LAST) begin
        run_cnt <= '0;
        Run_lvl <= ~Run_lvl;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end

      if (clr_sync == ClrLd_lvl) begin
        clr_cnt <= '0;
      end else if (clr_cnt >= CNT_LAST) begin
        clr_cnt   <= '0;
        ClrLd_lvl <= ~ClrLd_lvl;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end

      Run_pulse   <= run_fire;
      ClrLd_pulse <= clr_fire;

      s_meta <= S;
      Sw     <= s_meta;
      // Sw here is the pre-edge value, i.e. the switches one cycle earlier.
      if (clr_fire) begin
        Sw_snap <= Sw;
      end
    end
  end

endmodule

// File: tb/tb_button_cond.sv
module tb_button_cond;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run_n = 1'b1;
  logic       ClearA_LoadB_n = 1'b1;
  logic [7:0] S = 8'h00;
  logic       Busy = 1'b0;
  logic       Run_lvl, ClrLd_lvl, Run_pulse, ClrLd_pulse;
  logic [7:0] Sw, Sw_snap;

  int checks = 0;
  int errors = 0;

  button_cond #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset), .Run_n(Run_n), .ClearA_LoadB_n(ClearA_LoadB_n),
    .S(S), .Busy(Busy), .Run_lvl(Run_lvl), .ClrLd_lvl(ClrLd_lvl),
    .Run_pulse(Run_pulse), .ClrLd_pulse(ClrLd_pulse), .Sw(Sw), .Sw_snap(Sw_snap)
  );

  always #5 Clk = ~Clk;

  // Advance one active edge; observe 1 time unit after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle(3);
    checks++;
    if ({Run_lvl, ClrLd_lvl, Run_pulse, ClrLd_pulse, Sw, Sw_snap} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got lvl=%b%b pulse=%b%b Sw=%h snap=%h want all 0",
               Run_lvl, ClrLd_lvl, Run_pulse, ClrLd_pulse, Sw, Sw_snap);
    end
    Reset = 1'b0;
    idle(5);
  endtask

  task automatic test_latency();
    int extra;
    Run_n = 1'b0;                       // first sampled at edge 1
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (Run_lvl !== 1'b0 || Run_pulse !== 1'b0) begin
        errors++;
        $display("FAIL latency_early edge %0d got lvl=%b pulse=%b want 0 0", i, Run_lvl, Run_pulse);
      end
    end
    tick();                             // edge 6 = 1+1+4
    checks++;
    if (Run_lvl !== 1'b1 || Run_pulse !== 1'b1) begin
      errors++;
      $display("FAIL latency_edge6 got lvl=%b pulse=%b want 1 1", Run_lvl, Run_pulse);
    end
    tick();
    checks++;
    if (Run_pulse !== 1'b0 || Run_lvl !== 1'b1) begin
      errors++;
      $display("FAIL pulse_width got lvl=%b pulse=%b want 1 0", Run_lvl, Run_pulse);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Run_pulse) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL hold_single_pulse got %0d extra pulses want 0", extra);
    end
    Run_n = 1'b1;
    extra = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (Run_lvl !== 1'b1) extra++;
      if (Run_pulse) extra++;
    end
    tick();
    if (Run_pulse) extra++;
    checks++;
    if (extra !== 0 || Run_lvl !== 1'b0) begin
      errors++;
      $display("FAIL release_latency got lvl=%b bad=%0d want lvl 0 bad 0", Run_lvl, extra);
    end
    idle(3);
  endtask

  task automatic test_bounce();
    int seen;
    int pulses;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      ClearA_LoadB_n = ((i / 2) % 2) != 0;
      tick();
      if (ClrLd_lvl || ClrLd_pulse) seen++;
    end
    ClearA_LoadB_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ClrLd_lvl || ClrLd_pulse) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL bounce_clrld got %0d active cycles want 0", seen);
    end
    // Three low samples: one short of acceptance.
    seen = 0;
    Run_n = 1'b0;
    idle(3);
    Run_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Run_lvl || Run_pulse) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL bounce_n_minus_1 got %0d active cycles want 0", seen);
    end
    // Four low samples: just enough.
    pulses = 0;
    Run_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (Run_pulse) pulses++;
    end
    Run_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (Run_pulse) pulses++;
    end
    checks++;
    if (pulses !== 1 || Run_lvl !== 1'b0) begin
      errors++;
      $display("FAIL bounce_exact_n got pulses=%0d lvl=%b want 1 0", pulses, Run_lvl);
    end
  endtask

  task automatic test_snap();
    S = 8'hA5;
    idle(3);
    ClearA_LoadB_n = 1'b0;
    idle(5);
    tick();                             // edge 6
    checks++;
    if (ClrLd_pulse !== 1'b1 || Sw_snap !== 8'hA5) begin
      errors++;
      $display("FAIL snap_capture got pulse=%b snap=%h want 1 a5", ClrLd_pulse, Sw_snap);
    end
    S = 8'h3C;
    tick();
    checks++;
    if (Sw !== 8'hA5 || ClrLd_pulse !== 1'b0) begin
      errors++;
      $display("FAIL sw_sync_1edge got Sw=%h pulse=%b want a5 0", Sw, ClrLd_pulse);
    end
    tick();
    checks++;
    if (Sw !== 8'h3C || Sw_snap !== 8'hA5) begin
      errors++;
      $display("FAIL sw_sync_2edge got Sw=%h snap=%h want 3c a5", Sw, Sw_snap);
    end
    idle(10);
    checks++;
    if (Sw_snap !== 8'hA5) begin
      errors++;
      $display("FAIL snap_hold got %h want a5", Sw_snap);
    end
    ClearA_LoadB_n = 1'b1;
    idle(10);
    // Sw changes on the same edge as the pulse: snapshot takes the older value.
    ClearA_LoadB_n = 1'b0;
    idle(4);
    S = 8'h77;
    idle(2);
    checks++;
    if (ClrLd_pulse !== 1'b1 || Sw !== 8'h77 || Sw_snap !== 8'h3C) begin
      errors++;
      $display("FAIL snap_prev_cycle got pulse=%b Sw=%h snap=%h want 1 77 3c",
               ClrLd_pulse, Sw, Sw_snap);
    end
    ClearA_LoadB_n = 1'b1;
    idle(10);
  endtask

  task automatic test_both();
    int rp, cp;
    rp = 0;
    cp = 0;
    Run_n = 1'b0;
    ClearA_LoadB_n = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (Run_pulse) rp++;
      if (ClrLd_pulse) cp++;
    end
    checks++;
    if (rp !== 1 || cp !== 0) begin
      errors++;
      $display("FAIL both_pulses got run=%0d clr=%0d want 1 0", rp, cp);
    end
    checks++;
    if (Run_lvl !== 1'b1 || ClrLd_lvl !== 1'b1 || Sw_snap !== 8'h3C) begin
      errors++;
      $display("FAIL both_levels got lvl=%b%b snap=%h want 11 3c", Run_lvl, ClrLd_lvl, Sw_snap);
    end
    Run_n = 1'b1;
    ClearA_LoadB_n = 1'b1;
    idle(10);
  endtask

  task automatic test_lockout();
    int rp;
    int want;
`ifdef BTN_COND_LOCKOUT_EN
    want = 0;
`else
    want = 1;
`endif
    rp = 0;
    Busy = 1'b1;
    Run_n = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (Run_pulse) rp++;
    end
    Busy = 1'b0;
    checks++;
    if (rp !== want || Run_lvl !== 1'b1) begin
      errors++;
      $display("FAIL busy_lockout got pulses=%0d lvl=%b want %0d 1", rp, Run_lvl, want);
    end
    Run_n = 1'b1;
    idle(10);
  endtask

  task automatic test_reset_mid();
    int bad;
    Run_n = 1'b0;
    idle(3);
    Reset = 1'b1;
    #1;
    checks++;
    if ({Run_lvl, ClrLd_lvl, Run_pulse, ClrLd_pulse, Sw, Sw_snap} !== 20'h0) begin
      errors++;
      $display("FAIL reset_async got lvl=%b%b pulse=%b%b Sw=%h snap=%h want all 0",
               Run_lvl, ClrLd_lvl, Run_pulse, ClrLd_pulse, Sw, Sw_snap);
    end
    idle(2);
    checks++;
    if ({Run_lvl, ClrLd_lvl, Run_pulse, ClrLd_pulse, Sw, Sw_snap} !== 20'h0) begin
      errors++;
      $display("FAIL reset_held got lvl=%b%b pulse=%b%b Sw=%h snap=%h want all 0",
               Run_lvl, ClrLd_lvl, Run_pulse, ClrLd_pulse, Sw, Sw_snap);
    end
    Reset = 1'b0;                       // released at edge 0
    bad = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (Run_pulse || Run_lvl) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_discard got %0d early active cycles want 0", bad);
    end
    tick();                             // edge 6 = 2+4
    checks++;
    if (Run_pulse !== 1'b1 || Run_lvl !== 1'b1) begin
      errors++;
      $display("FAIL reset_repress got pulse=%b lvl=%b want 1 1", Run_pulse, Run_lvl);
    end
    Run_n = 1'b1;
    idle(10);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_snap();
    test_both();
    test_lockout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
